mem_port_arbiter: RTL and testbench

//  Shares one single-port memory between instruction fetch (I) and data load/store (D) of the core.

---
 rtl/arb_pkg.sv | 9 +
 rtl/arb_timer.sv | 24 ++
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and default limits for the I/D memory port arbiter,
// also used by the fetch and LSU request logic.
package arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_e;
    typedef enum logic {REQ_I, REQ_D} req_id_e;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int TIMEOUT_DEF      = 16;
endpackage

// File: rtl/arb_timer.sv
// Saturating up-counter with clear and enable; hit is high while the count sits at LIMIT.
module arb_timer #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);
    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] MAX = W'(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && cnt != MAX)
            cnt <= cnt + 1'b1;
    end

    assign hit = (cnt == MAX);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store,
// with D-priority arbitration, I starvation relief and a hung-access timeout.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic          err,
    output logic          cpu_stall
);
    arb_state_e state;
    req_id_e    winner;
    logic       busy, grant, done, abort, starve_hit, to_hit;

    always_comb begin
        winner = REQ_D;
        if (!d_req || (i_req && starve_hit))
            winner = REQ_I;
    end

    assign busy      = (state != IDLE);
    assign grant     = !rst && !busy && (i_req || d_req);
    assign i_gnt     = grant && (winner == REQ_I);
    assign d_gnt     = grant && (winner == REQ_D);
    assign done      = busy && mem_ready;
    // mem_ready in the limit cycle is a normal completion, so abort excludes it
    assign abort     = busy && !mem_ready && to_hit;
    assign cpu_stall = i_req || d_req || busy;

    arb_timer #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk(clk), .rst(rst), .clr(!i_req || i_gnt), .en(d_gnt), .hit(starve_hit)
    );

    arb_timer #(.LIMIT(TIMEOUT - 1)) u_timeout (
        .clk(clk), .rst(rst), .clr(!busy), .en(!mem_ready), .hit(to_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_gnt) begin
                        state     <= BUSY_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                    end else if (d_gnt) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end
                end
                default: begin
                    if (done || abort) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        err     <= abort;
                        if (state == BUSY_I) begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= abort ? '0 : mem_rdata;
                        end else begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= (abort || mem_we) ? '0 : mem_rdata;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int STARVE  = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, mem_we, err, cpu_stall;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err), .cpu_stall(cpu_stall)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding access, a wait count and a starvation tally.
    bit          m_busy, m_isd, m_we;
    logic [31:0] m_addr, m_wdata;
    int          m_wait, m_starve;
    bit          e_irv, e_drv, e_err;
    logic [31:0] e_rdata;
    bit          last_ig, last_dg;
    int          n_irv;
    bit          gq[$];

    // Inputs are set by the caller; outputs checked at negedge, model advanced, then returns at posedge+1.
    task automatic tick();
        bit iwin, ig, dg;
        @(negedge clk);
        iwin = !d_req || (i_req && m_starve >= STARVE);
        ig   = !rst && !m_busy && i_req && iwin;
        dg   = !rst && !m_busy && d_req && !iwin;
        chk("i_gnt", i_gnt, ig);
        chk("d_gnt", d_gnt, dg);
        chk("mem_req", mem_req, m_busy);
        if (m_busy) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("i_rvalid", i_rvalid, e_irv);
        chk("d_rvalid", d_rvalid, e_drv);
        chk("err", err, e_err);
        if (e_irv) chk("i_rdata", i_rdata, e_rdata);
        if (e_drv) chk("d_rdata", d_rdata, e_rdata);
        chk("cpu_stall", cpu_stall, i_req || d_req || m_busy);
        n_irv += int'(i_rvalid);
        if (i_gnt || d_gnt) gq.push_back(i_gnt);

        e_irv = 0; e_drv = 0; e_err = 0;
        if (rst) begin
            m_busy = 0; m_starve = 0;
        end else begin
            if (m_busy) begin
                if (mem_ready || m_wait == TIMEOUT - 1) begin
                    e_irv   = !m_isd;
                    e_drv   = m_isd;
                    e_err   = !mem_ready;
                    e_rdata = (!mem_ready || m_we) ? 32'h0 : mem_rdata;
                    m_busy  = 0;
                end else m_wait++;
            end else if (ig || dg) begin
                m_busy  = 1;
                m_wait  = 0;
                m_isd   = dg;
                m_we    = dg && d_we;
                m_addr  = dg ? d_addr : i_addr;
                m_wdata = d_wdata;
            end
            if (ig || !i_req) m_starve = 0;
            else if (dg && m_starve < STARVE) m_starve++;
        end
        last_ig = ig;
        last_dg = dg;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_run(input int n, input int pct);
        for (int c = 0; c < n; c++) begin
            if (!i_req || last_ig) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = $urandom;
            end
            if (!d_req || last_dg) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = ($urandom_range(0, 1) != 0);
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            mem_ready = ($urandom_range(0, 99) < pct);
            mem_rdata = $urandom;
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0; i_req = 0; d_req = 0; mem_ready = 0;
        repeat (TIMEOUT + 2) tick();
    endtask

    initial begin
        int k;
        logic [9:0] seq;
        rst = 1; i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        m_busy = 0; m_starve = 0; n_irv = 0;
        @(posedge clk); #1;

        // 1: reset state, then a single fetch
        repeat (3) tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rvalid", {i_rvalid, d_rvalid, err}, 0);
        chk("rst_rdata", {i_rdata, d_rdata}, 0);
        rst = 0; i_req = 1; i_addr = 32'h0;
        #1 chk("t1_gnt", i_gnt, 1);
        tick();
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'h0);
        i_req = 0; mem_ready = 1; mem_rdata = 32'h00500093;
        tick();
        mem_ready = 0;
        chk("t1_rvalid", i_rvalid, 1);
        chk("t1_rdata", i_rdata, 32'h00500093);
        tick();

        // 2: simultaneous requests, D store wins first
        i_req = 1; i_addr = 32'h44; d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        #1 chk("t2_dgnt", d_gnt, 1);
        tick();
        d_req = 0;
        tick();
        chk("t2_mem_we", mem_we, 1);
        chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
        mem_ready = 1; mem_rdata = 32'h12345678;
        tick();
        mem_ready = 0;
        chk("t2_drvalid", d_rvalid, 1);
        chk("t2_drdata", d_rdata, 0);
        chk("t2_igwin", i_gnt, 1);
        chk("t2_stall", cpu_stall, 1);
        tick();
        i_req = 0; mem_ready = 1;
        tick();
        mem_ready = 0;
        tick();

        // 3: starvation relief, pattern DDDDI repeating
        i_req = 1; d_req = 1; d_we = 0; mem_ready = 1;
        gq.delete();
        repeat (20) tick();
        seq = '0;
        for (int j = 0; j < 10 && j < gq.size(); j++) seq[j] = gq[j];
        chk("t3_ngnt", gq.size(), 10);
        chk("t3_seq", seq, 10'b1000010000);
        i_req = 0; d_req = 0; mem_ready = 0;
        repeat (2) tick();

        // 4: load that never completes times out
        d_req = 1; d_we = 0; d_addr = 32'h200;
        tick();
        d_req = 0;
        k = 0;
        while (!d_rvalid && k < 40) begin tick(); k++; end
        chk("t4_lat", k, 16);
        chk("t4_err", err, 1);
        chk("t4_rdata", d_rdata, 0);
        tick();
        chk("t4_idle", mem_req, 0);

        // 5: mem_ready in the timeout cycle completes normally
        d_req = 1; d_addr = 32'h300;
        tick();
        d_req = 0;
        repeat (15) tick();
        mem_ready = 1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ready = 0;
        chk("t5_rvalid", d_rvalid, 1);
        chk("t5_err", err, 0);
        chk("t5_rdata", d_rdata, 32'hCAFEF00D);
        tick();

        // 6: reset mid-fetch abandons it; stray mem_ready in IDLE ignored
        i_req = 1; i_addr = 32'h40;
        tick();
        i_req = 0;
        tick();
        n_irv = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("t6_mem_req", mem_req, 0);
        mem_ready = 1;
        tick();
        mem_ready = 0;
        repeat (3) tick();
        chk("t6_no_rvalid", n_irv, 0);
        i_req = 1; i_addr = 32'h80;
        tick();
        i_req = 0; mem_ready = 1; mem_rdata = 32'h00000013;
        tick();
        mem_ready = 0;
        chk("t6_rvalid", i_rvalid, 1);
        chk("t6_rdata", i_rdata, 32'h00000013);
        tick();

        // randomized traffic: fast memory, then a slow one that hits timeouts
        rand_run(3000, 40);
        rand_run(1500, 4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
